spindle_ia_spike_gen: RTL and testbench

Downstream stage of the spindle model. Takes the muscle afferent firing rate (IEEE-754 single, pulses/s) and turns it into a discrete spike train on the simulation timestep grid.
- Latches a new rate on a strobe, converts it float-to-integer and clamps it.
- On every timestep tick, adds the rate to a phase accumulator.
- Emits a fixed-width spike pulse when the accumulator crosses TICK_HZ; keeps a running spike count.
- Feeds spike-driven neuron and motoneuron stages and the host readout.

---
 rtl/spindle_ia_spike_gen.sv | 127 ++++++++++++
 tb/tb_spindle_ia_spike_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/spindle_ia_spike_gen.sv
// Spindle afferent rate-to-spike generator: float rate in, phase accumulator
// per timestep tick, fixed-width retriggerable spike pulse and running count.
module spindle_ia_spike_gen #(
  parameter int unsigned TICK_HZ     = 1000,
  parameter int unsigned SPIKE_WIDTH = 4,
  parameter int unsigned ACC_W       = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] rate_in,
  input  logic        rate_valid,
  input  logic        tick,
  output logic        spike,
  output logic [31:0] spike_count,
  output logic [31:0] rate_int
);

  localparam int unsigned CNT_W = (SPIKE_WIDTH > 1) ? $clog2(SPIKE_WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [31:0]      count_q, count_d;
  logic [31:0]      rate_int_q, rate_int_d;
  logic             spike_q, spike_d;
  logic [31:0]      rate_conv;
  logic [ACC_W-1:0] sum;
  logic             fire;

  // Truncating float-to-int with saturation at TICK_HZ; negatives, NaN and
  // sub-unity values collapse to zero.
  function automatic logic [31:0] f2i(input logic [31:0] f);
    logic [7:0]  e;
    logic [31:0] m;
    logic [31:0] v;
    e = f[30:23];
    m = {8'd0, 1'b1, f[22:0]};
    v = '0;
    if (e == 8'd255) begin
      v = (f[22:0] != 23'd0 || f[31]) ? 32'd0 : 32'(TICK_HZ);
    end else if (f[31] || e < 8'd127) begin
      v = '0;
    end else if (e >= 8'd159) begin
      v = 32'(TICK_HZ);
    end else if (e <= 8'd150) begin
      v = m >> (8'd150 - e);
    end else begin
      v = m << (e - 8'd150);
    end
    if (v > 32'(TICK_HZ)) v = 32'(TICK_HZ);
    return v;
  endfunction

  assign rate_conv = f2i(rate_in);
  assign sum       = acc_q + ACC_W'(rate_int_q);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    wcnt_d     = wcnt_q;
    count_d    = count_q;
    rate_int_d = rate_int_q;
    fire       = 1'b0;

    if (rate_valid) rate_int_d = rate_conv;

    // Phase accumulator uses the rate latched before this edge.
    if (tick) begin
      if (sum >= ACC_W'(TICK_HZ)) begin
        acc_d = sum - ACC_W'(TICK_HZ);
        fire  = 1'b1;
      end else begin
        acc_d = sum;
      end
    end

    case (state_q)
      IDLE: begin
        if (fire) begin
          state_d = PULSE;
          wcnt_d  = CNT_W'(SPIKE_WIDTH - 1);
        end
      end
      PULSE: begin
        if (fire) begin
          wcnt_d = CNT_W'(SPIKE_WIDTH - 1);
        end else if (wcnt_q == '0) begin
          state_d = IDLE;
        end else begin
          wcnt_d = wcnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (fire) count_d = count_q + 32'd1;
    spike_d = (state_d == PULSE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      wcnt_q     <= '0;
      count_q    <= '0;
      rate_int_q <= '0;
      spike_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      wcnt_q     <= wcnt_d;
      count_q    <= count_d;
      rate_int_q <= rate_int_d;
      spike_q    <= spike_d;
    end
  end

  assign spike       = spike_q;
  assign spike_count = count_q;
  assign rate_int    = rate_int_q;

endmodule

// File: tb/tb_spindle_ia_spike_gen.sv
// Scoreboard bench for spindle_ia_spike_gen: stimulus pushes expected fires,
// a negedge monitor pops them whenever spike_count advances.
module tb_spindle_ia_spike_gen;

  localparam int unsigned TICK_HZ     = 1000;
  localparam int unsigned SPIKE_WIDTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] rate_in = '0;
  logic        rate_valid = 1'b0;
  logic        tick = 1'b0;
  logic        spike;
  logic [31:0] spike_count;
  logic [31:0] rate_int;

  spindle_ia_spike_gen #(.TICK_HZ(TICK_HZ), .SPIKE_WIDTH(SPIKE_WIDTH), .ACC_W(24)) dut (
    .clk(clk), .reset(reset), .rate_in(rate_in), .rate_valid(rate_valid),
    .tick(tick), .spike(spike), .spike_count(spike_count), .rate_int(rate_int)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic        mon_en = 1'b0;
  logic [31:0] prev_cnt = '0;
  logic        prev_spike = 1'b0;
  int unsigned last_fire = 0;

  // Reference state of the stimulus side
  int unsigned m_acc = 0;
  int unsigned m_rate = 0;
  logic [31:0] m_cnt = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h want 0x%08h at cyc %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: every spike_count step is one fire the scoreboard must own.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (spike_count !== prev_cnt) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_fire", spike_count, prev_cnt);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("fire_cycle", cyc, e.cyc);
          chk("fire_count", spike_count, e.cnt);
          chk("spike_on_fire", {31'd0, spike}, 32'd1);
          last_fire = cyc;
        end
      end
      if (prev_spike && !spike) chk("pulse_width", cyc - last_fire, SPIKE_WIDTH);
    end
    prev_cnt   <= spike_count;
    prev_spike <= spike;
  end

  task automatic model_tick();
    int unsigned s;
    s = m_acc + m_rate;
    if (s >= TICK_HZ) begin
      m_acc = s - TICK_HZ;
      m_cnt = m_cnt + 32'd1;
      exp_q.push_back('{cyc: cyc + 1, cnt: m_cnt});
    end else begin
      m_acc = s;
    end
  endtask

  // One tick, optionally with a simultaneous rate strobe; next tick gap clk later.
  task automatic do_tick(input int gap, input logic upd, input logic [31:0] bits,
                         input int unsigned exp_rate);
    @(negedge clk);
    tick = 1'b1;
    if (upd) begin
      rate_in    = bits;
      rate_valid = 1'b1;
    end
    model_tick();
    if (upd) m_rate = exp_rate;
    @(negedge clk);
    tick       = 1'b0;
    rate_valid = 1'b0;
    repeat (gap - 2) @(negedge clk);
  endtask

  task automatic set_rate(input string name, input logic [31:0] bits, input int unsigned exp_rate);
    @(negedge clk);
    rate_in    = bits;
    rate_valid = 1'b1;
    @(negedge clk);
    rate_valid = 1'b0;
    m_rate     = exp_rate;
    chk(name, rate_int, exp_rate);
  endtask

  initial begin
    logic [31:0] base;
    repeat (3) @(negedge clk);
    chk("reset_spike", {31'd0, spike}, 32'd0);
    chk("reset_count", spike_count, 32'd0);
    chk("reset_rate", rate_int, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // 100 pps: one spike per 10 ticks
    set_rate("rate_100", 32'h42C80000, 100);
    for (int i = 0; i < 1000; i++) do_tick(10, 1'b0, '0, 0);
    chk("count_after_100pps", spike_count, 32'd100);

    // Sub-unity, negative and NaN rates never fire
    set_rate("rate_0p75", 32'h3F400000, 0);
    for (int i = 0; i < 50; i++) do_tick(4, 1'b0, '0, 0);
    set_rate("rate_neg5", 32'hC0A00000, 0);
    for (int i = 0; i < 50; i++) do_tick(4, 1'b0, '0, 0);
    set_rate("rate_nan", 32'h7FC00000, 0);
    for (int i = 0; i < 50; i++) do_tick(4, 1'b0, '0, 0);
    chk("count_after_zero_rates", spike_count, 32'd100);
    set_rate("rate_inf", 32'h7F800000, 1000);
    set_rate("rate_big_exp", 32'h4F800000, 1000);

    // Saturation: every tick fires, spike held by retrigger
    set_rate("rate_1e6", 32'h49742400, 1000);
    base = spike_count;
    for (int i = 0; i < 20; i++) begin
      do_tick(3, 1'b0, '0, 0);
      chk("spike_held", {31'd0, spike}, 32'd1);
    end
    chk("count_saturate", spike_count - base, 32'd20);
    repeat (8) @(negedge clk);

    // Phase preserved across a rate change coincident with a tick
    set_rate("rate_500", 32'h43FA0000, 500);
    base = spike_count;
    for (int i = 0; i < 4; i++) do_tick(10, 1'b0, '0, 0);
    chk("count_500", spike_count - base, 32'd2);
    do_tick(10, 1'b1, 32'h43480000, 200);
    chk("rate_200", rate_int, 32'd200);
    for (int i = 0; i < 10; i++) do_tick(10, 1'b0, '0, 0);
    chk("count_phase", spike_count - base, 32'd4);

    // Reset mid-pulse, then restart from acc=0
    set_rate("rate_700", 32'h442F0000, 700);
    do_tick(2, 1'b0, '0, 0);
    @(negedge clk);
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    chk("rst_mid_spike", {31'd0, spike}, 32'd0);
    chk("rst_mid_count", spike_count, 32'd0);
    chk("rst_mid_rate", rate_int, 32'd0);
    exp_q.delete();
    m_acc = 0; m_rate = 0; m_cnt = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    set_rate("rate_300", 32'h43960000, 300);
    for (int i = 0; i < 3; i++) do_tick(10, 1'b0, '0, 0);
    chk("no_fire_before_threshold", spike_count, 32'd0);
    do_tick(10, 1'b0, '0, 0);
    chk("fire_after_restart", spike_count, 32'd1);

    // Count wrap via backdoor preload
    set_rate("rate_1000", 32'h447A0000, 1000);
    @(negedge clk);
    mon_en = 1'b0;
    force dut.count_q = 32'hFFFFFFFF;
    @(negedge clk);
    release dut.count_q;
    @(negedge clk);
    chk("count_preload", spike_count, 32'hFFFFFFFF);
    m_cnt = 32'hFFFFFFFF;
    @(negedge clk);
    mon_en = 1'b1;
    do_tick(10, 1'b0, '0, 0);
    chk("count_wrap", spike_count, 32'h00000000);

    repeat (10) @(negedge clk);
    chk("pending_fires", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: got timeout want finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
